// File: rtl/sel_delay_pkg.sv
// Shared constants and helpers for the selectable delay pipeline.
package sel_delay_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 2;
  localparam int unsigned DEF_NCH   = 4;

  // Bits needed to count 0..depth valid entries.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Low bit index of channel c in a packed multi-channel bus.
  function automatic int unsigned slice_lo(input int unsigned c, input int unsigned width);
    return c * width;
  endfunction

endpackage

// File: rtl/sel_delay_lane.sv
// One channel: DEPTH-stage delay chain, output register and occupancy count.
module sel_delay_lane
  import sel_delay_pkg::*;
#(
  parameter  int unsigned WIDTH = DEF_WIDTH,
  parameter  int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned OW    = occ_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             slow,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [OW-1:0]    occ
);

  logic [DEPTH-1:0] sv;
  logic [WIDTH-1:0] sd [DEPTH];

  // Chain and output register; data loads unconditionally, valid only tags it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sv        <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) sd[k] <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      sv        <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) sd[k] <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (slow) begin
      sv[0] <= in_valid;
      sd[0] <= in_data;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        sv[k] <= sv[k-1];
        sd[k] <= sd[k-1];
      end
      out_valid <= sv[DEPTH-1];
      out_data  <= sd[DEPTH-1];
    end else begin
      out_valid <= in_valid;
      out_data  <= in_data;
    end
  end

  // Popcount of the stage valid bits, from registered state only.
  always_comb begin
    occ = '0;
    for (int unsigned k = 0; k < DEPTH; k++) occ = occ + OW'(sv[k]);
  end

endmodule

// File: rtl/sel_delay_pipe.sv
// NCH independent delay lanes with per-channel direct/chain path select.
module sel_delay_pipe
  import sel_delay_pkg::*;
#(
  parameter  int unsigned WIDTH = DEF_WIDTH,
  parameter  int unsigned DEPTH = DEF_DEPTH,
  parameter  int unsigned NCH   = DEF_NCH,
  localparam int unsigned OW    = occ_width(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       slow,
  input  logic                 flush,
  output logic [NCH-1:0]       out_valid,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic [NCH*OW-1:0]    occ
);

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    sel_delay_lane #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid[c]),
      .in_data  (in_data[slice_lo(c, WIDTH) +: WIDTH]),
      .slow     (slow[c]),
      .flush    (flush),
      .out_valid(out_valid[c]),
      .out_data (out_data[slice_lo(c, WIDTH) +: WIDTH]),
      .occ      (occ[slice_lo(c, OW) +: OW])
    );
  end

endmodule

// File: tb/tb_sel_delay_pipe.sv
// Randomized bench for sel_delay_pipe against a queue-based reference model.
module tb_sel_delay_pipe;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned NCH   = 4;
  localparam int unsigned OW    = $clog2(DEPTH + 1);

  typedef logic [WIDTH:0] word_t;  // {valid, data}

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NCH-1:0]       in_valid;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       slow;
  logic                 flush;
  logic [NCH-1:0]       out_valid;
  logic [NCH*WIDTH-1:0] out_data;
  logic [NCH*OW-1:0]    occ;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference: per channel, a DEPTH-long queue, newest word at the front.
  word_t          chain [NCH][$];
  logic           m_ov  [NCH];
  logic [WIDTH-1:0] m_od [NCH];

  sel_delay_pipe #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .NCH  (NCH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .slow     (slow),
    .flush    (flush),
    .out_valid(out_valid),
    .out_data (out_data),
    .occ      (occ)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      chain[c].delete();
      for (int k = 0; k < DEPTH; k++) chain[c].push_back('0);
      m_ov[c] = 1'b0;
      m_od[c] = '0;
    end
  endtask

  // Apply one clock edge worth of the behavioural rules to the model.
  task automatic model_step();
    word_t w;
    if (flush) begin
      model_clear();
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (slow[c]) begin
          w = chain[c].pop_back();
          m_ov[c] = w[WIDTH];
          m_od[c] = w[WIDTH-1:0];
          chain[c].push_front({in_valid[c], in_data[c*WIDTH +: WIDTH]});
        end else begin
          m_ov[c] = in_valid[c];
          m_od[c] = in_data[c*WIDTH +: WIDTH];
        end
      end
    end
  endtask

  task automatic compare(input string phase);
    int unsigned cnt;
    for (int c = 0; c < NCH; c++) begin
      cnt = 0;
      foreach (chain[c][k]) cnt += chain[c][k][WIDTH];
      check($sformatf("%s ov%0d", phase, c), 32'(out_valid[c]), 32'(m_ov[c]));
      check($sformatf("%s od%0d", phase, c), 32'(out_data[c*WIDTH +: WIDTH]), 32'(m_od[c]));
      check($sformatf("%s occ%0d", phase, c), 32'(occ[c*OW +: OW]), cnt);
    end
  endtask

  task automatic drive_idle();
    in_valid = '0;
    in_data  = '0;
    slow     = '0;
    flush    = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    model_clear();
    #1 compare("reset");
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      in_valid = NCH'($urandom);
      in_data  = (NCH*WIDTH)'($urandom);
      if (i < 150)      slow = '1;
      else if (i < 200) slow = 4'b0101;
      else              slow = NCH'($urandom);
      flush = ($urandom_range(0, 24) == 0);
      @(posedge clk);
      model_step();
      #1 compare("run");

      if (i == 120 || i == 400) begin
        // Reset between edges while chains hold data.
        #2 rst = 1'b1;
        drive_idle();
        model_clear();
        #1 compare("async_rst");
        @(posedge clk);
        #1 compare("rst_hold");
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        model_step();
        #1 compare("rst_release");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sel_delay_pipe.md
# sel_delay_pipe

Multi-channel, parametrised delay pipeline with a per-channel path select. When a channel's `slow` bit is set, its data goes through a DEPTH-stage delay chain; when clear, data goes directly to the output register and the chain holds its contents. The block sits between a tainted input domain and a sink and is a regression target for information-flow and constant-time checks. Every datum carries a valid tag end to end, so the verifier can track which input word reaches which output cycle.

## Interface

- `WIDTH`, 8, data bits per channel.
- `DEPTH`, 2, delay-chain stages per channel (≥1).
- `NCH`, 4, independent channels.
- Derived: `OW = $clog2(DEPTH+1)`, occupancy width.

Ports:

- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  NCH  per-channel input valid tag.
- `in_data`  in  NCH*WIDTH  channel c at bits [c*WIDTH +: WIDTH].
- `slow`  in  NCH  per-channel path select: 1 = delay chain, 0 = direct.
- `flush`  in  1  global synchronous clear of all chains.
- `out_valid`  out  NCH  registered valid tag.
- `out_data`  out  NCH*WIDTH  registered data, same packing as `in_data`.
- `occ`  out  NCH*OW  per-channel count of valid entries in the chain.

## Operation

Each channel c is independent. Each channel holds:

- stages s[0..DEPTH-1], each {v, d};
- output register {out_valid[c], out_data[c]}.

Per posedge, the first matching rule applies:

- **`flush`=1:** all s[k].v ← 0 and s[k].d ← 0. out_valid[c] ← 0 and out_data[c] ← 0. The input this cycle is dropped on every channel, whatever `slow` is.
- **`slow[c]`=1 (chain advances):**
  - s[0] ← {in_valid[c], in_data[c]};
  - s[k] ← s[k-1] for k ≥ 1;
  - output ← s[DEPTH-1] (valid and data, pre-edge values).
- **`slow[c]`=0 (chain frozen):**
  - all s[k] hold;
  - output ← {in_valid[c], in_data[c]}.

General rules:

- Data fields load unconditionally; invalid words still move, and the valid bit only tags them. No data-dependent control anywhere, so timing depends only on `slow`, `flush` and `rst`.
- `occ[c]` is the combinational popcount of s[*].v for channel c, derived from registered state only. Range 0..DEPTH, never wraps.
- Toggling `slow` mid-stream is legal:
  - frozen entries keep their order and resume on the next `slow`=1 cycle;
  - a word written directly while the chain is frozen can leave before older chained words. This reordering is intended behaviour.

## Timing

- **Reset:** asserting `rst` clears all s[k], `out_valid`, `out_data` and `occ` to 0 immediately, without waiting for a clock edge. Deassertion takes effect at the next posedge.
- **Reset mid-operation:** in-flight words are lost and never appear at the output.
- **Direct-path latency:** 1 cycle. A word sampled at edge n is visible after edge n.
- **Chain latency:** DEPTH+1 edges during which `slow[c]`=1. Frozen cycles do not count.
- **Chain output:** the output register is written every cycle, so `out_valid[c]` can be 1 for exactly one cycle per word.
- **`flush` with `rst`:** `rst` dominates.

## Structure

- Shared package `sel_delay_pkg`:
  - default WIDTH, DEPTH and NCH constants;
  - occupancy-width function;
  - channel slice index helper.
- Sub-module `sel_delay_lane`: one channel (chain, output register, popcount), parametrised by WIDTH and DEPTH.
- Top level: a generate loop of NCH lanes plus port packing. The lane is also the unit for the information-flow annotations.

## Test plan

All scenarios use WIDTH=8, DEPTH=2, NCH=4.

1. **Async reset:** assert `rst` between edges while the chains hold data → `out_valid`=0, `out_data`=0 and `occ`=0 before the next posedge. After deassertion, one edge with no input keeps the outputs at 0.
2. **Direct path:** `slow`=0, ch0 `in_data`=0xA5 with valid at edge 1 → after edge 1, `out_valid[0]`=1 and `out_data[0]`=0xA5. After edge 2 with no input, `out_valid[0]`=0.
3. **Chain path:** `slow[1]`=1, feed 0x11, 0x22, 0x33 valid on edges 1–3 → `occ[1]`=1 then 2; 0x11 emerges after edge 3 and 0x22 after edge 4.
4. **Freeze and resume:**
   - load 0x44 into ch2 with `slow`=1 for 1 edge;
   - then `slow`=0 for 5 edges with 0x55 valid on the first of them → 0x55 emerges after 1 edge and `occ[2]` stays 1;
   - then `slow`=1 with no valid input → 0x44 emerges after 2 edges, then `occ[2]`=0.
5. **Flush collision:** chain ch3 holds 2 valid words; assert `flush` with `slow`=1 and input 0x66 valid → after that edge `occ[3]`=0 and `out_valid[3]`=0. Neither the held words nor 0x66 ever appear.
6. **Channel independence:** `slow`=4'b0101 with distinct bytes per channel → ch1 and ch3 show 1-cycle latency and ch0 and ch2 show 3-cycle latency, with no cross-channel corruption.
